// File: rtl/player_hop_ctrl_if.sv
// VGA-side bundle for the player controller: timing inputs from the VGA block
// and the per-pixel sprite flag returned to the RGB stage.
interface player_hop_ctrl_if;
  logic [9:0] haddr;
  logic [9:0] vaddr;
  logic       display_on;
  logic       vsync;
  logic       player_pix;

  modport master (
    output haddr,
    output vaddr,
    output display_on,
    output vsync,
    input  player_pix
  );

  modport slave (
    input  haddr,
    input  vaddr,
    input  display_on,
    input  vsync,
    output player_pix
  );
endinterface

// File: rtl/player_hop_ctrl.sv
// Chicken controller: debounced hop button, frame-paced hop FSM, lane/score tracking
// and sprite pixel flag. Optional macro PLAYER_BLINK_EN blinks the sprite while DEAD.
module player_hop_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOP_FRAMES      = 8,
  parameter int LANE_HEIGHT     = 32,
  parameter int NUM_LANES       = 15,
  parameter int START_LANE      = 14,
  parameter int PLAYER_X        = 304,
  parameter int SPRITE_W        = 32
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               move_i,
  input  logic               hit_i,
  player_hop_ctrl_if.slave   vga,
  output logic [3:0]         player_lane_o,
  output logic [7:0]         score_o,
  output logic               hopping_o,
  output logic               dead_o
);

  localparam int DBW     = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 2;
  localparam int HCW     = ($clog2(HOP_FRAMES) > 0) ? $clog2(HOP_FRAMES) : 1;
  localparam int START_C = (START_LANE < NUM_LANES) ? START_LANE : NUM_LANES - 1;

  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCW-1:0] HOP_LAST   = HCW'(HOP_FRAMES - 1);
  localparam logic [3:0]     LANE_START = 4'(START_C);
  localparam logic [9:0]     LANE_H     = 10'(LANE_HEIGHT);
  localparam logic [9:0]     Y_STEP     = 10'(LANE_HEIGHT / HOP_FRAMES);
  localparam logic [10:0]    X_LO       = 11'(PLAYER_X);
  localparam logic [10:0]    X_HI       = 11'(PLAYER_X + SPRITE_W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOP  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  logic           sync1_q, sync2_q;
  logic           db_lvl_q, db_lvl_d, db_prev_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           vsync_q;
  logic           press_s, tick_s;
  logic [1:0]     state_q, state_d;
  logic [HCW-1:0] hop_cnt_q, hop_cnt_d;
  logic [3:0]     lane_q, lane_d;
  logic [7:0]     score_q, score_d;
  logic           hopping_q, dead_q, pix_q;
  logic           pix_s, x_hit_s, y_hit_s;
  logic [9:0]     y_off_s, player_y_s;
  logic [10:0]    y_end_s;

  assign press_s = db_lvl_q & ~db_prev_q;
  assign tick_s  = vsync_q & ~vga.vsync;

  // The counter only runs while the synced sample disagrees with the debounced level.
  always_comb begin
    db_cnt_d = db_cnt_q;
    db_lvl_d = db_lvl_q;
    if (sync2_q == db_lvl_q) begin
      db_cnt_d = DBW'(0);
    end else if (db_cnt_q == DB_LAST) begin
      db_lvl_d = sync2_q;
      db_cnt_d = DBW'(0);
    end else begin
      db_cnt_d = db_cnt_q + DBW'(1);
    end
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_lvl_q  <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= DBW'(0);
      vsync_q   <= 1'b0;
    end else begin
      sync1_q   <= move_i;
      sync2_q   <= sync1_q;
      db_lvl_q  <= db_lvl_d;
      db_prev_q <= db_lvl_q;
      db_cnt_q  <= db_cnt_d;
      vsync_q   <= vga.vsync;
    end
  end

  // hit outranks tick, tick outranks press; presses while hopping are simply lost.
  always_comb begin
    state_d   = state_q;
    hop_cnt_d = hop_cnt_q;
    lane_d    = lane_q;
    score_d   = score_q;
    case (state_q)
      ST_IDLE: begin
        if (hit_i) begin
          state_d = ST_DEAD;
        end else if (press_s) begin
          state_d   = ST_HOP;
          hop_cnt_d = HCW'(0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOP: begin
        if (hit_i) begin
          state_d = ST_DEAD;
        end else if (tick_s) begin
          if (hop_cnt_q == HOP_LAST) begin
            state_d   = ST_IDLE;
            hop_cnt_d = HCW'(0);
            if (lane_q == 4'd0) begin
              lane_d  = LANE_START;
              score_d = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
            end else begin
              lane_d = lane_q - 4'd1;
            end
          end else begin
            hop_cnt_d = hop_cnt_q + HCW'(1);
          end
        end else begin
          state_d = ST_HOP;
        end
      end
      ST_DEAD: begin
        if (press_s) begin
          state_d   = ST_IDLE;
          lane_d    = LANE_START;
          score_d   = 8'd0;
          hop_cnt_d = HCW'(0);
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        hop_cnt_d = HCW'(0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= ST_IDLE;
      hop_cnt_q <= HCW'(0);
      lane_q    <= LANE_START;
      score_q   <= 8'd0;
      hopping_q <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hop_cnt_q <= hop_cnt_d;
      lane_q    <= lane_d;
      score_q   <= score_d;
      hopping_q <= (state_d == ST_HOP);
      dead_q    <= (state_d == ST_DEAD);
    end
  end

`ifdef PLAYER_BLINK_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      frame_cnt_q <= 8'd0;
    end else if (tick_s) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end
`endif

  // Sprite rises by Y_STEP per hop frame; 10-bit wrap above row 0 is intentional.
  always_comb begin
    if (state_q == ST_HOP) begin
      y_off_s = 10'(hop_cnt_q) * Y_STEP;
    end else begin
      y_off_s = 10'd0;
    end
    player_y_s = (10'(lane_q) * LANE_H) - y_off_s;
    y_end_s    = {1'b0, player_y_s} + {1'b0, LANE_H};
    x_hit_s    = ({1'b0, vga.haddr} >= X_LO) && ({1'b0, vga.haddr} < X_HI);
    y_hit_s    = (vga.vaddr >= player_y_s) && ({1'b0, vga.vaddr} < y_end_s);
    pix_s      = vga.display_on & x_hit_s & y_hit_s;
`ifdef PLAYER_BLINK_EN
    if (state_q == ST_DEAD) begin
      pix_s = pix_s & frame_cnt_q[3];
    end else begin
      pix_s = pix_s;
    end
`endif
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pix_q <= 1'b0;
    end else begin
      pix_q <= pix_s;
    end
  end

  assign vga.player_pix = pix_q;
  assign player_lane_o  = lane_q;
  assign score_o        = score_q;
  assign hopping_o      = hopping_q;
  assign dead_o         = dead_q;

endmodule

// File: tb/tb_player_hop_ctrl.sv
// Directed + randomized bench for player_hop_ctrl, checked against an event-level
// model (press / frame / hit) of lane, score, mode and sprite rectangle.
module tb_player_hop_ctrl;
  logic clk = 1'b0;
  logic sys_rst;
  logic move, hit;
  logic [3:0] lane;
  logic [7:0] score;
  logic hopping, dead;

  player_hop_ctrl_if vif ();

  player_hop_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOP_FRAMES(4),
    .LANE_HEIGHT(32)
  ) dut (
    .clk(clk),
    .sys_rst(sys_rst),
    .move_i(move),
    .hit_i(hit),
    .vga(vif),
    .player_lane_o(lane),
    .score_o(score),
    .hopping_o(hopping),
    .dead_o(dead)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  // model: mode 0 = standing, 1 = hopping, 2 = dead
  int m_lane, m_score, m_mode, m_hc;
  int lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_lane = 14; m_score = 0; m_mode = 0; m_hc = 0;
  endtask

  task automatic m_press();
    if (m_mode == 0) begin
      m_mode = 1; m_hc = 0;
    end else if (m_mode == 2) begin
      m_mode = 0; m_lane = 14; m_score = 0; m_hc = 0;
    end
  endtask

  task automatic m_tick();
    if (m_mode == 1) begin
      if (m_hc == 3) begin
        m_mode = 0; m_hc = 0;
        if (m_lane == 0) begin
          m_lane = 14;
          if (m_score < 255) m_score++;
        end else begin
          m_lane--;
        end
      end else begin
        m_hc++;
      end
    end
  endtask

  task automatic m_hit();
    if (m_mode != 2) m_mode = 2;
  endtask

  function automatic int m_top();
    return (m_lane * 32 - ((m_mode == 1) ? m_hc * 8 : 0)) & 1023;
  endfunction

  function automatic logic m_pix(int h, int v, int d);
    int t;
    t = m_top();
    return (d != 0) && (h >= 304) && (h < 336) && (v >= t) && (v < t + 32);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".lane"}, 32'(lane), m_lane);
    chk({tag, ".score"}, 32'(score), m_score);
    chk({tag, ".hopping"}, 32'(hopping), (m_mode == 1) ? 1 : 0);
    chk({tag, ".dead"}, 32'(dead), (m_mode == 2) ? 1 : 0);
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic press(input int hold, input int rel);
    move = 1'b1;
    repeat (hold) @(negedge clk);
    move = 1'b0;
    repeat (rel) @(negedge clk);
    m_press();
  endtask

  task automatic frame(input int lo, input int hi);
    vif.vsync = 1'b0;
    repeat (lo) @(negedge clk);
    vif.vsync = 1'b1;
    repeat (hi) @(negedge clk);
    m_tick();
  endtask

  task automatic hit_pulse();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    m_hit();
  endtask

  task automatic probe(input string tag, input int h, input int v, input int d, input logic exp);
    vif.haddr = 10'(h);
    vif.vaddr = 10'(v);
    vif.display_on = (d != 0);
    @(posedge clk);
    #1;
    chk(tag, 32'(vif.player_pix), 32'(exp));
    @(negedge clk);
  endtask

  task automatic fast_hop();
    press(8, 0);
    repeat (4) frame(1, 1);
  endtask

  initial begin
    int rows[5];
    logic seen;
    int top, h, v, d, r;
    sys_rst = 1'b0; move = 1'b0; hit = 1'b0;
    vif.vsync = 1'b1; vif.display_on = 1'b0; vif.haddr = 10'd0; vif.vaddr = 10'd0;
    m_reset();
    repeat (3) @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);

    // 1. reset state and static sprite
    check_state("reset");
    chk("reset.pix", 32'(vif.player_pix), 0);
    probe("pix_in", 304, 448, 1, 1'b1);
    probe("pix_left", 303, 448, 1, 1'b0);
    probe("pix_blank", 304, 448, 0, 1'b0);
    probe("pix_right", 335, 479, 1, 1'b1);
    probe("pix_below", 335, 480, 1, 1'b0);

    // 2. bouncing button never produces a hop
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i < 40) move = ((i / 2) % 2 == 0);
      else move = 1'b0;
      @(negedge clk);
      if (hopping) seen = 1'b1;
    end
    chk("bounce_no_hop", 32'(seen), 0);
    move = 1'b1;
    lat = 0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      if (hopping && lat == 0) lat = i;
    end
    chk("press_latency_ok", 32'(lat != 0), 1);
    if (lat == 0) lat = 7;
    @(negedge clk);
    repeat (3) @(negedge clk);
    move = 1'b0;
    repeat (8) @(negedge clk);
    m_press();
    check_state("after_press");

    // 3. one hop: sprite climbs 8 rows per frame, extra press is dropped
    rows = '{448, 440, 432, 424, 416};
    for (int k = 0; k < 5; k++) begin
      probe("hop_top", 304, rows[k], 1, 1'b1);
      probe("hop_above", 304, rows[k] - 1, 1, 1'b0);
      if (k == 1) press(8, 8);
      if (k < 4) frame(2, 2);
    end
    check_state("hop_done");
    chk("hop_lane13", 32'(lane), 13);

    // 4. wrap and score saturation
    while (m_score < 255) begin
      fast_hop();
      if (m_lane == 0 || m_lane == 14) check_state("wrap");
    end
    chk("score_255", 32'(score), 255);
    repeat (15) fast_hop();
    chk("score_sat", 32'(score), 255);
    chk("sat_lane", 32'(lane), 14);
    repeat (8) @(negedge clk);

    // 5. collision mid-hop, recovery, hit+press in the same cycle
    press(8, 8);
    frame(2, 2);
    frame(2, 2);
    hit_pulse();
    check_state("hit_mid_hop");
    probe("dead_pix", 310, 14 * 32 + 5, 1, m_pix(310, 14 * 32 + 5, 1));
    press(8, 8);
    check_state("revive");
    move = 1'b1;
    repeat (lat - 1) @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    m_hit();
    repeat (4) @(negedge clk);
    move = 1'b0;
    repeat (8) @(negedge clk);
    check_state("hit_and_press");
    press(8, 8);
    check_state("revive2");

    // randomized actions against the model
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 7);
      if (r < 2) press(8, 8);
      else if (r < 5) frame(2, 2);
      else if (r == 5) hit_pulse();
      else begin
        top = m_top();
        h = 296 + $urandom_range(0, 47);
        v = (top + $urandom_range(0, 40) - 4) & 1023;
        d = ($urandom_range(0, 7) != 0) ? 1 : 0;
        probe("rand_pix", h, v, d, m_pix(h, v, d));
      end
      check_state("rand");
    end

    // 6. asynchronous reset in the middle of a hop
    if (m_mode == 2) press(8, 8);
    fast_hop();
    press(8, 0);
    frame(2, 2);
    frame(2, 2);
    #2;
    sys_rst = 1'b0;
    #1;
    m_reset();
    check_state("async_rst");
    chk("async_rst.pix", 32'(vif.player_pix), 0);
    repeat (2) @(negedge clk);
    sys_rst = 1'b1;
    repeat (3) frame(2, 2);
    repeat (6) @(negedge clk);
    check_state("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
